// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for a row of common-anode hex digits. A prescale
//   counter holds each digit active for PRESCALE cycles, then the digit index
//   advances; a one-cycle frame_done pulse marks the end of every full scan.
//   Display data is captured into registers on load, so the inputs may change
//   freely in between loads.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   value      in   4*NUM_DIGITS hex nibbles, digit k = value[4k+3:4k], digit 0 rightmost
//   blank      in   per-digit forced blank
//   dp_in      in   per-digit decimal point
//   lz_en      in   leading-zero suppression enable
//   load       in   capture value/blank/dp_in/lz_en on this edge
//   seg        out  segment bus {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   dp         out  decimal point of the active digit, same polarity as seg
//   an         out  active-low one-hot digit enables
//   frame_done out  one-cycle pulse after the digit index wraps to 0
module seven_seg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PC_W  = $clog2(PRESCALE);

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [PC_W-1:0]  pcnt;
  logic [IDX_W-1:0] idx;
  logic             digit_end;

  // Display registers
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic                    lz_q;

  // Per-digit decode helpers
  logic [NUM_DIGITS-1:0] hi_zero;    // digit k and all digits above it are zero
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] digit_off;  // digit shows no segments

  // Active-digit selection
  logic [3:0] nib;
  logic       off_act;
  logic       dp_act;
  logic [6:0] seg_on;

  // Active-high segment patterns, bit 0 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  assign digit_end = (pcnt == PC_LAST);

  // Scan timing is free-running and never touched by load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt       <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      // Registered so the pulse lands in the cycle after the wrap edge.
      frame_done <= digit_end && (idx == IDX_LAST);
      if (digit_end) begin
        pcnt <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Display registers. Blank resets to all ones so nothing lights until the
  // first load provides real data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q   <= '0;
      blank_q <= '1;
      dp_q    <= '0;
      lz_q    <= 1'b0;
    end else if (load) begin
      val_q   <= value;
      blank_q <= blank;
      dp_q    <= dp_in;
      lz_q    <= lz_en;
    end
  end

  // Walk from the most significant digit down, tracking whether every digit
  // seen so far is zero. Digit 0 is excluded from suppression so an all-zero
  // value still shows a single "0".
  always_comb begin
    hi_zero   = '0;
    digit_off = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (val_q[4*k +: 4] == 4'h0);
      hi_zero[k]   = zero_run;
      digit_off[k] = blank_q[k] || (lz_q && (k > 0) && hi_zero[k]);
    end
  end

  // Select the active digit. Everything here depends only on registered
  // state, so outputs move only when idx changes or after a load.
  always_comb begin
    nib     = 4'h0;
    off_act = 1'b1;
    dp_act  = 1'b0;
    an      = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib     = val_q[4*k +: 4];
        off_act = digit_off[k];
        dp_act  = dp_q[k];
        an[k]   = 1'b0;
      end
    end
  end

  assign seg_on = off_act ? 7'h00 : hex_to_seg(nib);
  assign seg    = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
  assign dp     = SEG_ACTIVE_LOW ? ~dp_act : dp_act;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (NUM_DIGITS=4, PRESCALE=4, SEG_ACTIVE_LOW=1).
// A behavioural model tracks scan position and display data; at every clock
// edge its expected outputs are pushed to exp_q and popped/compared 1 ns later.
module tb_seven_seg_scanner;

  localparam int NUM_DIGITS = 4;
  localparam int PRESCALE   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [15:0] value  = '0;
  logic [3:0]  blank  = '0;
  logic [3:0]  dp_in  = '0;
  logic        lz_en  = 1'b0;
  logic        load   = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seven_seg_scanner #(
    .NUM_DIGITS     (NUM_DIGITS),
    .PRESCALE       (PRESCALE),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .blank      (blank),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          m_pcnt;
  int          m_idx;
  logic        m_fd;
  logic [15:0] m_val;
  logic [3:0]  m_blank;
  logic [3:0]  m_dp;
  logic        m_lz;
  int          fd_seen;

  // Packed expectation: {frame_done, dp, an[3:0], seg[6:0]}
  logic [12:0] exp_q [$];

  task automatic model_reset();
    m_pcnt  = 0;
    m_idx   = 0;
    m_fd    = 1'b0;
    m_val   = '0;
    m_blank = '1;
    m_dp    = '0;
    m_lz    = 1'b0;
  endtask

  function automatic logic [12:0] model_out();
    int         k;
    logic [3:0] a;
    logic       off;
    logic [6:0] s;
    k    = m_idx;
    a    = 4'hF;
    a[k] = 1'b0;
    // Higher digits all zero <=> the value shifted down to digit k is zero.
    off  = m_blank[k] || (m_lz && (k > 0) && ((m_val >> (4*k)) == 16'h0));
    s    = off ? 7'h7F : ~seg_tab[m_val[4*k +: 4]];
    return {m_fd, ~m_dp[k], a, s};
  endfunction

  // One clock: advance the model with the inputs present at the edge, push
  // the expectation, then compare against the DUT 1 ns after the edge.
  task automatic step();
    logic [12:0] e;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_fd = (m_pcnt == PRESCALE - 1) && (m_idx == NUM_DIGITS - 1);
      if (m_pcnt == PRESCALE - 1) begin
        m_pcnt = 0;
        m_idx  = (m_idx == NUM_DIGITS - 1) ? 0 : m_idx + 1;
      end else begin
        m_pcnt++;
      end
      if (load) begin
        m_val   = value;
        m_blank = blank;
        m_dp    = dp_in;
        m_lz    = lz_en;
      end
    end
    exp_q.push_back(model_out());
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("an", {28'h0, an}, {28'h0, e[10:7]});
      check_eq("seg", {25'h0, seg}, {25'h0, e[6:0]});
      check_eq("dp", {31'h0, dp}, {31'h0, e[11]});
      check_eq("frame_done", {31'h0, frame_done}, {31'h0, e[12]});
    end
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b,
                         input logic [3:0] d, input logic lz);
    value = v;
    blank = b;
    dp_in = d;
    lz_en = lz;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    fd_seen = 0;

    // Reset state: digit 0 enabled, all segments off, dp off, no pulse.
    run(3);
    check_eq("rst_an", {28'h0, an}, 32'hE);
    check_eq("rst_seg", {25'h0, seg}, 32'h7F);
    check_eq("rst_dp", {31'h0, dp}, 32'h1);
    check_eq("rst_fd", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Scan timing with 1234; any 32 consecutive cycles hold exactly 2 pulses.
    do_load(16'h1234, 4'h0, 4'h0, 1'b0);
    run(8);
    fd_seen = 0;
    run(32);
    check_eq("fd_per_32", fd_seen, 32'd2);

    // Full decode sweep through digit 0, random upper digits.
    for (int n = 0; n < 16; n++) begin
      do_load({4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'(n)}, 4'h0, 4'h0, 1'b0);
      run(16);
    end

    // Leading-zero suppression.
    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    run(20);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    run(20);
    // Nonzero top digit keeps inner zeros lit.
    do_load(16'h1000, 4'h0, 4'h0, 1'b1);
    run(20);

    // Blank and dp on digit 2.
    do_load(16'h8888, 4'b0100, 4'b0100, 1'b0);
    run(20);

    // Load coinciding with a digit advance.
    for (int i = 0; i < 8 && m_pcnt != PRESCALE - 1; i++) step();
    check_eq("align_pcnt", m_pcnt, PRESCALE - 1);
    do_load(16'hBEEF, 4'h0, 4'b1010, 1'b0);
    run(20);

    // Random traffic: inputs wiggle constantly, load only occasionally.
    for (int i = 0; i < 200; i++) begin
      value = 16'($urandom_range(0, 65535));
      blank = 4'($urandom_range(0, 15));
      dp_in = 4'($urandom_range(0, 15));
      lz_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) value = 16'($urandom_range(0, 255));
      load  = ($urandom_range(0, 7) == 0);
      step();
    end
    load = 1'b0;

    // Reset mid-scan at idx 2, asserted between edges.
    do_load(16'h1234, 4'h0, 4'hF, 1'b0);
    for (int i = 0; i < 16 && m_idx != 2; i++) step();
    check_eq("align_idx", m_idx, 2);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_an", {28'h0, an}, 32'hE);
    check_eq("mid_rst_seg", {25'h0, seg}, 32'h7F);
    check_eq("mid_rst_dp", {31'h0, dp}, 32'h1);
    check_eq("mid_rst_fd", {31'h0, frame_done}, 32'h0);
    run(3);
    @(negedge clk);
    reset_n = 1'b1;
    fd_seen = 0;
    run(15);
    check_eq("no_fd_after_rst", fd_seen, 32'd0);
    run(2);
    check_eq("fd_after_full_scan", fd_seen, 32'd1);
    do_load(16'h00A0, 4'h0, 4'h1, 1'b1);
    run(20);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
